// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pin and game-side signal bundle for keypad_scanner
interface keypad_scanner_if;
   logic [3:0] row_in;
   logic       hold_off;
   logic [3:0] col_out;
   logic [3:0] keypad_data;
   logic       keypad_enable;
   logic       key_held;

   modport master (
      input  row_in,
      input  hold_off,
      output col_out,
      output keypad_data,
      output keypad_enable,
      output key_held
   );

   modport slave (
      output row_in,
      output hold_off,
      input  col_out,
      input  keypad_data,
      input  keypad_enable,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with ghost rejection and press/release debounce
module keypad_scanner #(
   parameter int SCAN_DIV = 5000,
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic reset,
   keypad_scanner_if.master bus
);
   localparam int               DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB      = 4'(DEBOUNCE);

   typedef enum logic [1:0] {S_IDLE, S_DEB_PRESS, S_PRESSED, S_DEB_REL} state_t;

   state_t           r_state, w_state_nx;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_col;
   logic [1:0]       r_hits;
   logic [3:0]       r_first;
   logic [3:0]       r_cnt, w_cnt_nx;
   logic [3:0]       r_cand, w_cand_nx;
   logic [3:0]       r_data;
   logic             r_en;
   logic             r_held;

   logic       w_tick, w_frame_end;
   logic [2:0] w_col_hits, w_sum;
   logic [1:0] w_col_row, w_hits_nx;
   logic [3:0] w_first_nx;
   logic       w_is_key, w_is_none, w_accept, w_release;

   assign w_tick      = (r_div == DIV_LAST);
   assign w_frame_end = w_tick && (r_col == 2'd3);

   // Lowest pressed row of the driven column is the one kept as a first-hit code.
   always_comb begin
      w_col_hits = 3'd0;
      w_col_row  = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!bus.row_in[r]) begin
            w_col_hits = w_col_hits + 3'd1;
            w_col_row  = 2'(r);
         end
      end
   end

   assign w_sum      = {1'b0, r_hits} + w_col_hits;
   assign w_hits_nx  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
   assign w_first_nx = ((r_hits == 2'd0) && (w_col_hits != 3'd0)) ? {w_col_row, r_col} : r_first;
   assign w_is_none  = (w_hits_nx == 2'd0);
   assign w_is_key   = (w_hits_nx == 2'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div   <= '0;
         r_col   <= 2'd0;
         r_hits  <= 2'd0;
         r_first <= 4'd0;
      end else if (w_tick) begin
         r_div <= '0;
         r_col <= r_col + 2'd1;
         if (r_col == 2'd3) begin
            r_hits  <= 2'd0;
            r_first <= 4'd0;
         end else begin
            r_hits  <= w_hits_nx;
            r_first <= w_first_nx;
         end
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_cand_nx  = r_cand;
      w_accept   = 1'b0;
      w_release  = 1'b0;
      if (w_frame_end) begin
         case (r_state)
            S_IDLE: begin
               if (w_is_key) begin
                  w_cand_nx = w_first_nx;
                  if (DEB == 4'd1) begin
                     w_accept   = 1'b1;
                     w_cnt_nx   = 4'd0;
                     w_state_nx = S_PRESSED;
                  end else begin
                     w_cnt_nx   = 4'd1;
                     w_state_nx = S_DEB_PRESS;
                  end
               end
            end
            S_DEB_PRESS: begin
               if (w_is_key && (w_first_nx == r_cand)) begin
                  if (r_cnt + 4'd1 >= DEB) begin
                     w_accept   = 1'b1;
                     w_cnt_nx   = 4'd0;
                     w_state_nx = S_PRESSED;
                  end else begin
                     w_cnt_nx = r_cnt + 4'd1;
                  end
               end else if (w_is_key) begin
                  w_cand_nx = w_first_nx;
                  w_cnt_nx  = 4'd1;
               end else begin
                  w_cnt_nx   = 4'd0;
                  w_state_nx = S_IDLE;
               end
            end
            S_PRESSED: begin
               if (w_is_none) begin
                  if (DEB == 4'd1) begin
                     w_release  = 1'b1;
                     w_cnt_nx   = 4'd0;
                     w_state_nx = S_IDLE;
                  end else begin
                     w_cnt_nx   = 4'd1;
                     w_state_nx = S_DEB_REL;
                  end
               end
            end
            S_DEB_REL: begin
               if (!w_is_none) begin
                  w_cnt_nx   = 4'd0;
                  w_state_nx = S_PRESSED;
               end else if (r_cnt + 4'd1 >= DEB) begin
                  w_release  = 1'b1;
                  w_cnt_nx   = 4'd0;
                  w_state_nx = S_IDLE;
               end else begin
                  w_cnt_nx = r_cnt + 4'd1;
               end
            end
            default: begin
               w_cnt_nx   = 4'd0;
               w_state_nx = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_cand  <= 4'd0;
         r_data  <= 4'd0;
         r_en    <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_cand  <= w_cand_nx;
         r_en    <= w_accept && !bus.hold_off;
         if (w_accept) begin
            r_data <= w_first_nx;
            r_held <= 1'b1;
         end else if (w_release) begin
            r_held <= 1'b0;
         end
      end
   end

   assign bus.col_out       = ~(4'b0001 << r_col);
   assign bus.keypad_data   = r_data;
   assign bus.keypad_enable = r_en;
   assign bus.key_held      = r_held;
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 matrix keypad and produces the `keypad_data` / `keypad_enable` pair consumed by the game module.
- Scans the columns in turn, samples the rows, rejects ghosted multi-key frames and debounces both press and release.
- Emits exactly one single-cycle strobe per debounced key press.
- Sits between the board keypad pins and the game logic. Its `hold_off` input is tied to the game's music-playing indication, so presses made during playback are discarded.

Parameters:
- SCAN_DIV, 5000: clocks spent driving each column. Rows are sampled on the last clock of the column period. Legal range is 2 or more.
- DEBOUNCE, 4: consecutive identical scan frames required to accept a press, and consecutive empty frames required to accept a release. Legal range is 1 to 15.

Ports:
- clk  input  1  system clock; every flop is rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- row_in  input  4  keypad row lines, active-low (pulled up); bit r = row r.
- hold_off  input  1  when 1, debounced presses complete silently and no strobe is emitted.
- col_out  output  4  column drive, one-hot-low; bit c low = column c driven.
- keypad_data  output  4  code of the last accepted key = {row[1:0], col[1:0]}.
- keypad_enable  output  1  one-clock strobe; keypad_data is valid in the same cycle.
- key_held  output  1  1 while a debounced key is considered down.

Behaviour:
- Reset (reset=0, asynchronous):
  - col_out=4'b1110; column index 0; divider 0.
  - Frame accumulators cleared.
  - keypad_data=0, keypad_enable=0, key_held=0.
  - State IDLE; stable counter 0.
  - Reset mid-frame or mid-debounce discards all progress. No strobe is emitted on reset release.
- Divider: counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it samples row_in for the current column, wraps to 0 and advances the column index.
  - Column index wraps 3->0. col_out changes on the same edge as the index.
- Sampling: a row bit at 0 means the key (row r, current column) is pressed. Per frame the block keeps a hit count, saturating at 2, and the code of the first hit.
- Frame end: the sample of column 3. The frame result is NONE (0 hits), KEY(code) (exactly 1 hit) or MULTI (2 or more hits). The accumulators then clear for the next frame.
- Frame length = 4*SCAN_DIV clocks. The FSM updates only at frame end.
- FSM, evaluated at frame end (cnt = stable counter):
  - IDLE:
    - KEY(k): candidate=k, cnt=1, go to DEB_PRESS.
    - When DEBOUNCE=1, KEY(k) accepts the press immediately (same actions as DEB_PRESS acceptance).
    - NONE or MULTI: stay in IDLE.
  - DEB_PRESS:
    - KEY(same candidate): cnt+1.
    - When cnt reaches DEBOUNCE, accept: keypad_data=candidate, key_held=1, go to PRESSED, and pulse keypad_enable for 1 clock unless hold_off=1 on that clock.
    - KEY(different code): candidate=new code, cnt=1.
    - NONE or MULTI: go to IDLE, cnt=0.
  - PRESSED:
    - NONE: cnt=1, go to DEB_REL.
    - KEY (any code) or MULTI: stay in PRESSED. No second strobe; no key change while held.
  - DEB_REL:
    - NONE: cnt+1. When cnt reaches DEBOUNCE, key_held=0 and go to IDLE.
    - KEY or MULTI: go back to PRESSED.
    - When DEBOUNCE=1, the first NONE frame in PRESSED releases directly to IDLE.
- Strobe timing:
  - keypad_enable is registered. It is high exactly on the clock after the accepting frame-end edge, and low on every other clock.
  - keypad_data is updated on the same edge and holds until the next accepted press.
- hold_off is sampled on the accepting edge only. A press accepted under hold_off still enters PRESSED, so releasing hold_off while the key is still down produces no strobe.
- Press-to-strobe latency from a stable press = DEBOUNCE full frames, plus the partial frame in progress, plus 1 clock.
- Counter widths: divider ceil(log2(SCAN_DIV)) bits; stable counter 4 bits. No counter may wrap past its terminal value.

Test Plan:
- Reset, then SCAN_DIV=4, DEBOUNCE=3, no key held -> col_out walks 1110,1101,1011,0111 with 4 clocks per column; keypad_enable stays 0 for 200 clocks.
- Hold row 2 low only while column 1 is driven, stable for 3+ frames -> exactly one keypad_enable pulse 1 clock wide, keypad_data=4'h9, key_held=1. Key released for 3 frames -> key_held=0 and no further pulses.
- Bounce: key 4'h5 active for 2 frames, absent for 1, active for 3 -> exactly one pulse (data 5), issued at the end of the third consecutive frame.
- Keys (r0,c0) and (r1,c2) pressed simultaneously from IDLE -> MULTI each frame, no pulse; drop (r1,c2) -> one pulse after 3 frames with keypad_data=0.
- hold_off=1 during acceptance of key 4'hC -> no pulse and key_held=1. Drop hold_off while key still held -> still no pulse. Release, re-press -> pulse with data C.
- Assert reset=0 in DEB_PRESS at cnt=2 -> outputs return to reset values immediately; after release of reset, the held key needs a full 3 frames before its pulse.
